// File: rtl/rc_pwm_capture.sv
// Six-channel RC servo PWM high-time capture with per-channel range check and link-loss timeout.
// Optional glitch filter: define RC_GLITCH_FILTER_EN (adds 2 clocks to both edges).
module rc_pwm_capture #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int W          = 12,
  parameter int MIN_US     = 800,
  parameter int MAX_US     = 2200,
  parameter int CENTER_US  = 1500,
  parameter int TIMEOUT_US = 50_000
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [5:0]     Rec_Pwm,
  output logic [6*W-1:0] Pulse_Width,
  output logic [5:0]     New_Sample,
  output logic [5:0]     Pulse_Err,
  output logic [5:0]     Signal_Lost,
  output logic           All_Lost
);

  localparam int DIV  = CLK_HZ / 1_000_000;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCLG = $clog2(TIMEOUT_US + 1);
  localparam int TW   = (TCLG > 16) ? TCLG : 16;

  typedef enum logic [1:0] {IDLE, HIGH, STUCK} state_t;

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(DIV - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  // Synchronizer and level history reset high: a line that is already high when reset
  // releases is never seen as a rising edge, so a partial pulse cannot be measured.
  logic [5:0] sync1_q, sync2_q, level_q, level_d, rise, fall;

`ifdef RC_GLITCH_FILTER_EN
  logic [5:0] hist1_q, hist2_q, stable;

  assign stable  = ~(sync2_q ^ hist1_q) & ~(hist1_q ^ hist2_q);
  assign level_d = (stable & sync2_q) | (~stable & level_q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hist1_q <= '1;
      hist2_q <= '1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign level_d = sync2_q;
`endif

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
    end else begin
      sync1_q <= Rec_Pwm;
      sync2_q <= sync1_q;
      level_q <= level_d;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_ch
    state_t         state_q, state_d;
    logic [W-1:0]   wcnt_q, wcnt_d, width_q, width_d, wcnt_inc, wcnt_fin;
    logic [TW-1:0]  tcnt_q, tcnt_d, tcnt_inc;
    logic           ns_q, ns_d, err_q, err_d, lost_q, lost_d, valid, in_range;

    assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + W'(1);
    // A tick landing on the falling-edge clock still belongs to the pulse.
    assign wcnt_fin = tick ? wcnt_inc : wcnt_q;
    assign in_range = (wcnt_fin >= W'(MIN_US)) && (wcnt_fin <= W'(MAX_US));
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      width_d = width_q;
      ns_d    = 1'b0;
      err_d   = 1'b0;
      valid   = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise[gi]) begin
            state_d = HIGH;
            wcnt_d  = '0;
          end
        end
        HIGH: begin
          if (fall[gi]) begin
            state_d = IDLE;
            if (in_range) begin
              valid   = 1'b1;
              width_d = wcnt_fin;
              ns_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (tick) begin
            wcnt_d = wcnt_inc;
            if (wcnt_inc > W'(MAX_US)) begin
              err_d   = 1'b1;
              state_d = STUCK;
            end
          end
        end
        STUCK: begin
          if (fall[gi]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      tcnt_d = valid ? '0 : (tick ? tcnt_inc : tcnt_q);
      lost_d = valid ? 1'b0 : (lost_q || (tcnt_d >= TW'(TIMEOUT_US)));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        state_q <= IDLE;
        wcnt_q  <= '0;
        width_q <= W'(CENTER_US);
        tcnt_q  <= '0;
        ns_q    <= 1'b0;
        err_q   <= 1'b0;
        lost_q  <= 1'b1;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        width_q <= width_d;
        tcnt_q  <= tcnt_d;
        ns_q    <= ns_d;
        err_q   <= err_d;
        lost_q  <= lost_d;
      end
    end

    assign Pulse_Width[gi*W +: W] = width_q;
    assign New_Sample[gi]         = ns_q;
    assign Pulse_Err[gi]          = err_q;
    assign Signal_Lost[gi]        = lost_q;
  end

  assign All_Lost = &Signal_Lost;

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Directed bench for rc_pwm_capture: 2 MHz clock (tick every 2 clocks), 5 ms timeout.
`timescale 1ns/1ps
module tb_rc_pwm_capture;
  localparam int W = 12;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [5:0]    pwm;
  logic [6*W-1:0] Pulse_Width;
  logic [5:0]    New_Sample, Pulse_Err, Signal_Lost;
  logic          All_Lost;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ns_cnt[6];
  int err_cnt[6];
  int err_cyc[6];
  logic [5:0] last_ns_vec;

  rc_pwm_capture #(.CLK_HZ(2_000_000), .W(W), .TIMEOUT_US(5000)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rec_Pwm(pwm), .Pulse_Width(Pulse_Width),
    .New_Sample(New_Sample), .Pulse_Err(Pulse_Err), .Signal_Lost(Signal_Lost),
    .All_Lost(All_Lost)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      if (New_Sample[i]) ns_cnt[i] = ns_cnt[i] + 1;
      if (Pulse_Err[i]) begin
        err_cnt[i] = err_cnt[i] + 1;
        err_cyc[i] = cyc;
      end
    end
    if (New_Sample != 6'd0) last_ns_vec = New_Sample;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic int wid(input int ch);
    return int'(Pulse_Width[ch*W +: W]);
  endfunction

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clr();
    for (int i = 0; i < 6; i++) begin
      ns_cnt[i]  = 0;
      err_cnt[i] = 0;
      err_cyc[i] = 0;
    end
    last_ns_vec = 6'd0;
  endtask

  task automatic pulse(input logic [5:0] m, input int hi_us, input int lo_us);
    @(negedge Clk);
    pwm = pwm | m;
    wait_clk(hi_us * 2);
    pwm = pwm & ~m;
    wait_clk(lo_us * 2);
  endtask

  logic [71:0] center_vec;
  int t0, el, w_ok;

  initial begin
    center_vec = {6{12'd1500}};
    pwm   = 6'd0;
    Rst_n = 1'b0;
    clr();
    wait_clk(5);
    chk("reset_width", Pulse_Width, center_vec);
    chk("reset_strobes", {New_Sample, Pulse_Err}, 12'd0);
    chk("reset_lost", Signal_Lost, 6'h3F);
    chk("reset_all_lost", All_Lost, 1'b1);
    Rst_n = 1'b1;
    wait_clk(10);

    // Nominal 1500 us pulses on ch0
    clr();
    repeat (3) pulse(6'h01, 1500, 500);
    chk("t1_ns_count", ns_cnt[0], 3);
    chk("t1_err_count", err_cnt[0], 0);
    chk("t1_width", in_rng(wid(0), 1499, 1501), 1'b1);
    chk("t1_lost0", Signal_Lost[0], 1'b0);

    // Out-of-range and boundary pulses on ch3
    clr();
    pulse(6'h08, 799, 300);
    pulse(6'h08, 2201, 300);
    chk("t2_err_count", err_cnt[3], 2);
    chk("t2_ns_none", ns_cnt[3], 0);
    chk("t2_width_held", wid(3), 1500);
    pulse(6'h08, 800, 300);
    chk("t2_min_accept", ns_cnt[3], 1);
    chk("t2_min_width", in_rng(wid(3), 800, 801), 1'b1);
    pulse(6'h08, 2200, 300);
    chk("t2_max_accept", ns_cnt[3], 2);
    chk("t2_max_width", in_rng(wid(3), 2199, 2200), 1'b1);

    // Stuck-high on ch5
    clr();
    @(negedge Clk);
    t0 = cyc;
    pwm[5] = 1'b1;
    wait_clk(5000 * 2);
    pwm[5] = 1'b0;
    wait_clk(300 * 2);
    chk("t3_err_once", err_cnt[5], 1);
    chk("t3_ns_none", ns_cnt[5], 0);
    chk("t3_err_time", in_rng(err_cyc[5] - t0, 4396, 4412), 1'b1);
    pulse(6'h20, 1000, 300);
    chk("t3_recover_ns", ns_cnt[5], 1);
    chk("t3_recover_width", in_rng(wid(5), 999, 1001), 1'b1);

    // All channels, then silence until timeout
    clr();
    pulse(6'h3F, 1000, 0);
    t0 = cyc;
    wait_clk(20);
    chk("t4_simul_ns", last_ns_vec, 6'h3F);
    chk("t4_lost_clear", {All_Lost, Signal_Lost}, 7'd0);
    for (int k = 0; k < 12000 && !All_Lost; k++) @(negedge Clk);
    el = cyc - t0;
    chk("t4_all_lost", All_Lost, 1'b1);
    chk("t4_timeout_time", in_rng(el, 9996, 10010), 1'b1);
    chk("t4_lost_vec", Signal_Lost, 6'h3F);
    w_ok = 1;
    for (int i = 0; i < 6; i++) if (!in_rng(wid(i), 999, 1001)) w_ok = 0;
    chk("t4_width_hold", w_ok, 1);

    // Reset 10 us into a pulse on ch2
    pulse(6'h04, 1000, 100);
    clr();
    @(negedge Clk);
    pwm[2] = 1'b1;
    wait_clk(20);
    Rst_n = 1'b0;
    #1;
    chk("t5_rst_width", Pulse_Width, center_vec);
    chk("t5_rst_lost", {All_Lost, Signal_Lost}, 7'h7F);
    chk("t5_rst_strobes", {New_Sample, Pulse_Err}, 12'd0);
    wait_clk(3);
    Rst_n = 1'b1;
    wait_clk(1480 * 2);
    pwm[2] = 1'b0;
    wait_clk(300 * 2);
    chk("t5_aborted_pulse", ns_cnt[2] + err_cnt[2], 0);
    pulse(6'h04, 1200, 300);
    chk("t5_next_ns", ns_cnt[2], 1);
    chk("t5_next_width", in_rng(wid(2), 1199, 1201), 1'b1);

    // Two-clock glitch on ch1
    clr();
    @(negedge Clk);
    pwm[1] = 1'b1;
    wait_clk(2);
    pwm[1] = 1'b0;
    wait_clk(50);
    chk("t6_glitch_ns", ns_cnt[1], 0);
`ifdef RC_GLITCH_FILTER_EN
    chk("t6_glitch_err", err_cnt[1], 0);
`else
    chk("t6_glitch_err", err_cnt[1], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
